frame_sync_unpack: RTL

//  Receive-side counterpart of the packet serialiser. Takes a 1-bit serial stream, hunts for the
//  32-bit preamble 32'hCF80AA31 (normal or inverted polarity, limited bit errors tolerated) and

---
 rtl/frame_sync_unpack_pkg.sv | 16 +
 rtl/frame_sync_unpack_correlator.sv | 32 +++
 rtl/frame_sync_unpack.sv | 137 +++++++++++++
 3 files changed

// File: rtl/frame_sync_unpack_pkg.sv
// Frame format constants and sync FSM states shared by the packet serialiser and deserialiser.
package frame_pkg;

    localparam int SIZE_BIT_PACK   = 1976;
    localparam int SIZE_INPUT_BIT  = 1;
    localparam int SIZE_OUTPUT_BIT = 8;
    localparam int SIZE_PREAMBLE   = 32;
    localparam logic [SIZE_PREAMBLE-1:0] PREAMBLE = 32'hCF80AA31;
    localparam int MAX_ERR         = 2;

    typedef enum logic {
        SEARCH,
        PAYLOAD
    } sync_state_t;

endpackage

// File: rtl/frame_sync_unpack_correlator.sv
// Tolerant sync-word detector: flags a window within MAX_ERR bit errors of the preamble,
// separately for normal and inverted line polarity.
module preamble_correlator #(
    parameter int WIDTH   = frame_pkg::SIZE_PREAMBLE,
    parameter int MAX_ERR = frame_pkg::MAX_ERR
) (
    input  logic [WIDTH-1:0] sr_n,
    input  logic [WIDTH-1:0] preamble,
    output logic             match_pos,
    output logic             match_neg
);
    import frame_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] err_pos;
    logic [CNT_W-1:0] err_neg;

    // Hamming distance of the candidate window to the sync word and to its complement
    always_comb begin
        err_pos = '0;
        err_neg = '0;
        for (int i = 0; i < WIDTH; i++) begin
            err_pos = err_pos + CNT_W'(sr_n[i] ^ preamble[i]);
            err_neg = err_neg + CNT_W'(sr_n[i] ~^ preamble[i]);
        end
    end

    assign match_pos = (err_pos <= CNT_W'(MAX_ERR));
    assign match_neg = (err_neg <= CNT_W'(MAX_ERR));

endmodule

// File: rtl/frame_sync_unpack.sv
// Serial receive path: hunts for the preamble in either polarity, then packs a fixed-length
// payload MSB-first into bytes delivered through a single-entry valid/ready output register.
module frame_sync_unpack #(
    parameter int SIZE_BIT_PACK   = frame_pkg::SIZE_BIT_PACK,
    parameter int SIZE_INPUT_BIT  = frame_pkg::SIZE_INPUT_BIT,
    parameter int SIZE_OUTPUT_BIT = frame_pkg::SIZE_OUTPUT_BIT,
    parameter int SIZE_PREAMBLE   = frame_pkg::SIZE_PREAMBLE,
    parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE = frame_pkg::PREAMBLE,
    parameter int MAX_ERR         = frame_pkg::MAX_ERR,
    parameter int LENGTHE_OUTPUT  = SIZE_BIT_PACK / SIZE_OUTPUT_BIT
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [SIZE_INPUT_BIT-1:0]  i_data,
    input  logic                       i_valid_input,
    output logic                       o_ready,
    output logic [SIZE_OUTPUT_BIT-1:0] o_data,
    output logic                       o_valid,
    input  logic                       i_ready_output,
    output logic                       o_sop,
    output logic                       o_eop,
    output logic                       o_lock
);
    import frame_pkg::*;

    localparam int BIT_CNT_W  = $clog2(SIZE_OUTPUT_BIT);
    localparam int BYTE_CNT_W = $clog2(LENGTHE_OUTPUT);

    sync_state_t                state;
    sync_state_t                state_next;
    logic [SIZE_PREAMBLE-1:0]   sr;
    logic [SIZE_PREAMBLE-1:0]   sr_n;
    logic                       inv;
    logic [BIT_CNT_W-1:0]       bit_cnt;
    logic [SIZE_OUTPUT_BIT-1:0] byte_sr;
    logic [SIZE_OUTPUT_BIT-1:0] byte_n;
    logic [BYTE_CNT_W-1:0]      byte_cnt;
    logic                       accept;
    logic                       consume;
    logic                       byte_done;
    logic                       last_byte;
    logic                       match_pos;
    logic                       match_neg;

    assign accept    = i_valid_input && o_ready;
    assign consume   = o_valid && i_ready_output;
    assign sr_n      = {sr[SIZE_PREAMBLE-2:0], i_data[0]};
    assign byte_n    = {byte_sr[SIZE_OUTPUT_BIT-2:0], i_data[0] ^ inv};
    assign byte_done = accept && (state == PAYLOAD) && (bit_cnt == BIT_CNT_W'(SIZE_OUTPUT_BIT - 1));
    assign last_byte = (byte_cnt == BYTE_CNT_W'(LENGTHE_OUTPUT - 1));

    // Stall the line only when the byte about to complete has nowhere to go
    assign o_ready = !((state == PAYLOAD) && (bit_cnt == BIT_CNT_W'(SIZE_OUTPUT_BIT - 1)) &&
                       o_valid && !i_ready_output);
    assign o_lock  = (state == PAYLOAD);

    preamble_correlator #(
        .WIDTH   (SIZE_PREAMBLE),
        .MAX_ERR (MAX_ERR)
    ) u_correlator (
        .sr_n      (sr_n),
        .preamble  (PREAMBLE),
        .match_pos (match_pos),
        .match_neg (match_neg)
    );

    // Sync state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    // Lock on a tolerant preamble hit, release once the final payload byte is packed
    always_comb begin
        state_next = state;
        case (state)
            SEARCH:  if (accept && (match_pos || match_neg)) state_next = PAYLOAD;
            PAYLOAD: if (byte_done && last_byte)             state_next = SEARCH;
        endcase
    end

    // Preamble window, polarity flag and the bit/byte position inside the payload
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sr       <= '0;
            inv      <= 1'b0;
            bit_cnt  <= '0;
            byte_sr  <= '0;
            byte_cnt <= '0;
        end else if (accept) begin
            if (state == SEARCH) begin
                sr       <= sr_n;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                if (match_pos) begin
                    inv <= 1'b0;
                end else if (match_neg) begin
                    inv <= 1'b1;
                end
            end else begin
                byte_sr <= byte_n;
                if (byte_done) begin
                    bit_cnt <= '0;
                    if (last_byte) begin
                        byte_cnt <= '0;
                        sr       <= '0;
                    end else begin
                        byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
                    end
                end else begin
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                end
            end
        end
    end

    // Single-entry output register; a load may coincide with the consume of the previous byte
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
        end else if (byte_done) begin
            o_valid <= 1'b1;
            o_data  <= byte_n;
            o_sop   <= (byte_cnt == '0);
            o_eop   <= last_byte;
        end else if (consume) begin
            o_valid <= 1'b0;
        end
    end

endmodule
